// File: rtl/abacus_counter_sweeper.sv
// Wishbone master that snapshots the 16 ABACUS profiler counters into a small stream FIFO.
// Optional macro ABACUS_SWEEP_TIMESTAMP_EN prepends a cycle-count word (index 31) to each sweep.
module abacus_counter_sweeper #(
    parameter logic [31:0] ABACUS_BASE_ADDR = 32'hf0030000,
    parameter logic [31:0] SWEEP_PERIOD     = 32'd1000000,
    parameter int          ACK_TIMEOUT      = 16,
    parameter int          FIFO_DEPTH       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        sw_trigger,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [31:0] wb_adr,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic [4:0]  m_index,
    output logic        m_last,
    output logic        busy,
    output logic        overrun,
    output logic        timeout_err
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_TS, S_REQ, S_WAIT, S_PUSH} state_e;
    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  idx;
        logic        last;
    } entry_t;

    state_e          state_q, state_d;
    logic [3:0]      slot_q, slot_d;
    logic            cyc_q, cyc_d;
    logic [31:0]     adr_q, adr_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [31:0]     timer_q, timer_d;
    logic [TW-1:0]   to_q, to_d;
    logic            ovr_q, ovr_d;
    logic            terr_q, terr_d;
    entry_t          mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_q, rd_q;
    logic [PW:0]     cnt_q;
    logic            tick, req, push, pop, can_push;
    entry_t          push_e;

    // Slots 10..15 skip offset 0x20C in the cache counter block.
    function automatic logic [31:0] slot_addr(input logic [3:0] s);
        logic [31:0] off;
        if (s < 4'd10) begin
            off = 32'h100 + {26'd0, s, 2'b00};
        end else begin
            off = 32'h200 + {26'd0, s - 4'd10, 2'b00};
            if (s >= 4'd13) off = off + 32'd4;
        end
        return ABACUS_BASE_ADDR + off;
    endfunction

    always_comb begin
        timer_d = SWEEP_PERIOD - 32'd1;
        tick    = 1'b0;
        if (enable && SWEEP_PERIOD != 32'd0) begin
            if (timer_q == 32'd0) tick = 1'b1;
            else                  timer_d = timer_q - 32'd1;
        end
    end

    assign req      = tick | sw_trigger;
    assign m_valid  = (cnt_q != '0);
    assign pop      = m_valid & m_ready;
    assign can_push = (cnt_q != (PW+1)'(FIFO_DEPTH)) | pop;

`ifdef ABACUS_SWEEP_TIMESTAMP_EN
    logic [31:0] ts_q, ts_cap_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_q     <= '0;
            ts_cap_q <= '0;
        end else begin
            ts_q <= ts_q + 32'd1;
            if (state_q == S_IDLE && req) ts_cap_q <= ts_q;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        cyc_d   = cyc_q;
        adr_d   = adr_q;
        rdata_d = rdata_q;
        to_d    = to_q;
        ovr_d   = ovr_q;
        terr_d  = terr_q;
        push    = 1'b0;
        push_e  = '{data: rdata_q, idx: {1'b0, slot_q}, last: (slot_q == 4'd15)};
        if (req && state_q != S_IDLE) ovr_d = 1'b1;
        case (state_q)
            S_IDLE: if (req) begin
                if (sw_trigger) ovr_d = 1'b0;
                slot_d = '0;
                terr_d = 1'b0;
`ifdef ABACUS_SWEEP_TIMESTAMP_EN
                state_d = S_TS;
`else
                state_d = S_REQ;
`endif
            end
`ifdef ABACUS_SWEEP_TIMESTAMP_EN
            S_TS: begin
                push_e = '{data: ts_cap_q, idx: 5'd31, last: 1'b0};
                if (can_push) begin
                    push    = 1'b1;
                    state_d = S_REQ;
                end
            end
`endif
            S_REQ: begin
                cyc_d   = 1'b1;
                adr_d   = slot_addr(slot_q);
                to_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wb_ack) begin
                    rdata_d = wb_dat_i;
                    cyc_d   = 1'b0;
                    state_d = S_PUSH;
                end else if (to_q == TW'(ACK_TIMEOUT - 1)) begin
                    rdata_d = 32'hDEADBEEF;
                    cyc_d   = 1'b0;
                    terr_d  = 1'b1;
                    state_d = S_PUSH;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_PUSH: if (can_push) begin
                push = 1'b1;
                if (slot_q == 4'd15) begin
                    state_d = S_IDLE;
                end else begin
                    slot_d  = slot_q + 4'd1;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            slot_q  <= '0;
            cyc_q   <= 1'b0;
            adr_q   <= '0;
            rdata_q <= '0;
            timer_q <= SWEEP_PERIOD - 32'd1;
            to_q    <= '0;
            ovr_q   <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            cyc_q   <= cyc_d;
            adr_q   <= adr_d;
            rdata_q <= rdata_d;
            timer_q <= timer_d;
            to_q    <= to_d;
            ovr_q   <= ovr_d;
            terr_q  <= terr_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= push_e;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end

    assign wb_cyc      = cyc_q;
    assign wb_stb      = cyc_q;
    assign wb_we       = 1'b0;
    assign wb_adr      = adr_q;
    assign m_data      = mem_q[rd_q].data;
    assign m_index     = mem_q[rd_q].idx;
    assign m_last      = mem_q[rd_q].last;
    assign busy        = (state_q != S_IDLE);
    assign overrun     = ovr_q;
    assign timeout_err = terr_q;
endmodule

// File: tb/tb_abacus_counter_sweeper.sv
// Scoreboard bench for abacus_counter_sweeper: expected words/addresses queued at trigger, checked on output.
module tb_abacus_counter_sweeper;
    localparam logic [31:0] BASE = 32'hf0030000;
    localparam logic [11:0] OFFS [16] = '{12'h100, 12'h104, 12'h108, 12'h10C, 12'h110, 12'h114,
                                          12'h118, 12'h11C, 12'h120, 12'h124, 12'h200, 12'h204,
                                          12'h208, 12'h210, 12'h214, 12'h218};

    logic clk, rst, enable, sw_trigger;
    logic wb_cyc, wb_stb, wb_we, wb_ack;
    logic [31:0] wb_adr, wb_dat_i, m_data;
    logic m_valid, m_ready, m_last, busy, overrun, timeout_err;
    logic [4:0] m_index;

    int n_vec = 0, n_err = 0;
    int no_ack = -1;
    logic [31:0] cyc_cnt;
    logic [37:0] exp_q [$];
    logic [31:0] adr_q [$];
    logic stb_prev = 1'b0;
    int stb_len = 0;

    abacus_counter_sweeper #(.ABACUS_BASE_ADDR(BASE), .SWEEP_PERIOD(32'd200),
                             .ACK_TIMEOUT(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .sw_trigger(sw_trigger),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_dat_i(wb_dat_i), .wb_ack(wb_ack),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index),
        .m_last(m_last), .busy(busy), .overrun(overrun), .timeout_err(timeout_err));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int idx_of(input logic [31:0] a);
        for (int i = 0; i < 16; i++) if (a == BASE + {20'd0, OFFS[i]}) return i;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Registered slave: acks the cycle after it first sees stb, except the slot under test.
    assign wb_dat_i = 32'h100 + 32'(idx_of(wb_adr));
    always @(posedge clk or negedge rst) begin
        if (!rst) wb_ack <= 1'b0;
        else      wb_ack <= wb_cyc && wb_stb && !wb_ack && (idx_of(wb_adr) != no_ack);
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) cyc_cnt <= '0;
        else      cyc_cnt <= cyc_cnt + 32'd1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            stb_prev = 1'b0;
            stb_len  = 0;
        end else begin
            if (wb_stb && !stb_prev) begin
                chk("wb_we", {63'd0, wb_we}, 64'd0);
                if (adr_q.size() == 0) chk("adr_extra", 64'd1, 64'd0);
                else chk("wb_adr", {32'd0, wb_adr}, {32'd0, adr_q.pop_front()});
            end
            if (wb_stb) stb_len++;
            else if (stb_prev) begin
                if (idx_of(wb_adr) == no_ack) chk("to_len", 64'(stb_len), 64'd16);
                else                          chk("ack_len", 64'(stb_len), 64'd2);
                stb_len = 0;
            end
            stb_prev = wb_stb;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) chk("word_extra", 64'd1, 64'd0);
                else chk("word", {26'd0, m_data, m_index, m_last}, {26'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_sweep(input int bad, input logic [31:0] ts);
`ifdef ABACUS_SWEEP_TIMESTAMP_EN
        exp_q.push_back({ts, 5'd31, 1'b0});
`else
        if (ts == 32'hFFFF_FFFF) $display("unexpected timestamp value");
`endif
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back({(i == bad) ? 32'hDEADBEEF : 32'h100 + 32'(i), 5'(i), i == 15});
            adr_q.push_back(BASE + {20'd0, OFFS[i]});
        end
    endtask

    task automatic sweep_trig(input int bad);
        push_sweep(bad, cyc_cnt);
        sw_trigger = 1'b1;
        step(1);
        sw_trigger = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 3000) begin
            step(1);
            n++;
        end
        chk("drain_bound", 64'(n < 3000), 64'd1);
        chk("adr_left", 64'(adr_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(3);
        rst = 1'b1;
    endtask

    initial begin
        int n, stb_seen;
        rst = 1'b1; enable = 1'b0; sw_trigger = 1'b0; m_ready = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("rst_cyc", {63'd0, wb_cyc}, 64'd0);
        chk("rst_stb", {63'd0, wb_stb}, 64'd0);
        chk("rst_adr", {32'd0, wb_adr}, 64'd0);
        chk("rst_valid", {63'd0, m_valid}, 64'd0);
        chk("rst_data", {32'd0, m_data}, 64'd0);
        chk("rst_index", {59'd0, m_index}, 64'd0);
        chk("rst_last", {63'd0, m_last}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_ovr", {63'd0, overrun}, 64'd0);
        chk("rst_terr", {63'd0, timeout_err}, 64'd0);
        step(2);
        rst = 1'b1;
        step(2);

        // Basic sweep and its duration.
        sweep_trig(-1);
        chk("busy_set", {63'd0, busy}, 64'd1);
        n = 1;
        while (busy && n < 300) begin step(1); n++; end
        chk("sweep_len_min", 64'(n >= 64), 64'd1);
        chk("sweep_len_max", 64'(n < 100), 64'd1);
        wait_idle();
        chk("terr_clean", {63'd0, timeout_err}, 64'd0);

        // Slot 3 never acknowledged.
        no_ack = 3;
        sweep_trig(3);
        wait_idle();
        chk("terr_set", {63'd0, timeout_err}, 64'd1);
        no_ack = -1;
        sweep_trig(-1);
        chk("terr_clr", {63'd0, timeout_err}, 64'd0);
        wait_idle();

        // Backpressure: FIFO fills, the engine must stop issuing reads.
        m_ready = 1'b0;
        sweep_trig(-1);
        step(30);
        stb_seen = 0;
        for (int i = 0; i < 70; i++) begin
            if (wb_stb) stb_seen++;
            step(1);
        end
        chk("stall_stb", 64'(stb_seen), 64'd0);
        chk("stall_busy", {63'd0, busy}, 64'd1);
        chk("stall_valid", {63'd0, m_valid}, 64'd1);
        m_ready = 1'b1;
        wait_idle();

        // Overrun on trigger while busy; no extra sweep.
        sweep_trig(-1);
        step(10);
        sw_trigger = 1'b1; step(1); sw_trigger = 1'b0;
        chk("ovr_set", {63'd0, overrun}, 64'd1);
        wait_idle();
        step(100);
        chk("no_extra", {63'd0, busy}, 64'd0);
        chk("ovr_hold", {63'd0, overrun}, 64'd1);
        sweep_trig(-1);
        chk("ovr_clr", {63'd0, overrun}, 64'd0);
        wait_idle();

        // Periodic timer from reset release.
        rst = 1'b0;
        step(3);
        for (int k = 1; k <= 4; k++) push_sweep(-1, 32'(200 * k - 1));
        rst = 1'b1; enable = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            n = 0;
            while (!busy && n < 400) begin step(1); n++; end
            chk("tmr_start", {32'd0, cyc_cnt}, 64'(200 * k));
            n = 0;
            while (busy && n < 400) begin step(1); n++; end
        end
        while (cyc_cnt < 32'd950) step(1);
        enable = 1'b0;
        wait_idle();

        // Reset in the middle of slot 7.
        sweep_trig(-1);
        n = 0;
        while (!(wb_stb && wb_adr == BASE + 32'h11C) && n < 200) begin step(1); n++; end
        chk("slot7_reached", 64'(n < 200), 64'd1);
        rst = 1'b0;
        #1;
        chk("mid_cyc", {63'd0, wb_cyc}, 64'd0);
        chk("mid_stb", {63'd0, wb_stb}, 64'd0);
        chk("mid_valid", {63'd0, m_valid}, 64'd0);
        chk("mid_busy", {63'd0, busy}, 64'd0);
        exp_q.delete();
        adr_q.delete();
        step(3);
        rst = 1'b1;
        step(5);
        sweep_trig(-1);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/abacus_counter_sweeper.md
Name: abacus_counter_sweeper

Overview:
- Wishbone master sitting directly downstream of the ABACUS profiler register block.
- Periodically, or on a software trigger, reads the 16 profiler counter registers in fixed order and pushes each value into an internal FIFO.
- The FIFO drains through a valid/ready stream toward a UART/trace sink.
- Provides host-free, periodic counter snapshots without CPU involvement.

Parameters:
- ABACUS_BASE_ADDR, 32'hf0030000, base of the profiler register map.
- SWEEP_PERIOD, 32'd1000000, clock cycles between automatic sweeps; 0 disables the timer.
- ACK_TIMEOUT, 16, maximum cycles to wait for wb_ack per read.
- FIFO_DEPTH, 4, output FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- enable  in  1  enables the periodic timer
- sw_trigger  in  1  one-cycle pulse; requests a sweep
- wb_cyc  out  1  Wishbone cycle
- wb_stb  out  1  Wishbone strobe
- wb_we  out  1  write enable; constant 0
- wb_adr  out  32  read address
- wb_dat_i  in  32  read data from slave
- wb_ack  in  1  slave acknowledge
- m_valid  out  1  stream word valid
- m_ready  in  1  sink ready
- m_data  out  32  counter value
- m_index  out  5  slot index of m_data
- m_last  out  1  final word of a sweep
- busy  out  1  sweep in progress
- overrun  out  1  sticky: trigger arrived while busy; cleared by sw_trigger when not busy
- timeout_err  out  1  sticky: a read timed out; cleared at start of next sweep

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. On reset assertion, immediately and asynchronously: wb_cyc=wb_stb=0, wb_adr=0, FIFO empty, m_valid=0, m_data=0, m_index=0, m_last=0, busy=0, overrun=0, timeout_err=0, timer reloaded. A reset mid-transfer abandons the transfer; no word is pushed.
- Slot table, index 0..15: base+0x100,0x104,...,0x124 (10 instruction counters), then base+0x200,0x204,0x208,0x210,0x214,0x218 (cache counters).
- Timer: while enable=1 and SWEEP_PERIOD!=0, counts down from SWEEP_PERIOD-1. At 0 it emits a tick and reloads. enable=0 freezes and reloads the count.
- Start request: tick OR sw_trigger. In IDLE, a request starts a sweep. While busy, it sets overrun and is dropped. A tick and sw_trigger in the same cycle count as one request.
- FSM states: IDLE -> REQ -> WAIT -> PUSH -> (REQ for next slot | IDLE).
- IDLE->REQ: busy=1, slot=0, timeout_err cleared.
- REQ: drive wb_cyc=wb_stb=1 with wb_adr=slot address, then go to WAIT the next cycle.
- WAIT: hold cyc/stb/adr.
  - On wb_ack: latch wb_dat_i and drop cyc/stb in the same edge, so the slave sees stb low the cycle after ack.
  - If ACK_TIMEOUT cycles elapse without ack: drop cyc/stb, latch 32'hDEADBEEF, set timeout_err.
- PUSH: write {data, slot, slot==15} into the FIFO when not full; stall while full (no data is ever dropped).
  - After writing slot 15, return to IDLE with busy=0; otherwise slot+1 -> REQ.
- Minimum latency: 4 cycles per slot, so a 16-word sweep takes at least 64 cycles with no backpressure.
- FIFO: registered outputs. m_valid high whenever non-empty; a pop occurs when m_valid & m_ready.
  - Simultaneous push and pop while full is allowed.
  - The first word appears on m_valid one cycle after its push.
- enable deasserted mid-sweep: the current sweep completes.

Optional Feature:
- Macro ABACUS_SWEEP_TIMESTAMP_EN.
- When defined: a free-running 32-bit cycle counter (reset 0, wraps at 2^32) is captured on sweep start. A timestamp word is pushed first, with m_index=31 and m_last=0, before slot 0. No Wishbone access is made for it. A sweep is 17 words.
- When undefined: no timestamp counter; a sweep is 16 words, indices 0..15.

Test Plan:
- Slave acks 1 cycle after stb with data=0x100+index; sw_trigger pulse, m_ready=1 -> 16 words with m_data 0x100..0x10F and indices 0..15, m_last only on index 15, busy low 64+ cycles after trigger, wb_adr sequence matching the slot table.
- SWEEP_PERIOD=200, enable=1, run 1000 cycles -> sweeps start at cycles 200, 400, 600, 800 after reset release, each with 16 words.
- m_ready=0 for 100 cycles during a sweep -> FIFO holds 4 words, FSM stalls in PUSH, no wb_stb asserted while stalled; after m_ready=1 all 16 words arrive in order with no loss.
- Slave never acks slot 3 -> wb_stb drops after 16 cycles, slot 3 data=0xDEADBEEF, timeout_err=1, slots 4..15 normal; next sweep clears timeout_err.
- sw_trigger during a busy sweep -> overrun=1, no extra sweep; a later sw_trigger in IDLE clears overrun and starts a sweep.
- rst asserted while wb_stb=1 on slot 7 -> wb_cyc/wb_stb=0 immediately, m_valid=0. After release, sw_trigger restarts from slot 0. With ABACUS_SWEEP_TIMESTAMP_EN, the first word has index 31 and a value equal to the cycles since reset release at trigger.
